// File: rtl/switch_allocator_pkg.sv
// Shared constants for the mesh router switch allocator: address/direction
// widths, port numbering, direction encodings and the direction-to-port map.
package switch_allocator_pkg;

    localparam int unsigned ADDR_SZ  = 4;
    localparam int unsigned BITS_DIR = 3;
    localparam int unsigned NPORTS   = 5;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned MESH_DIM = 3;

    // Routing directions as produced by routing_table.
    typedef enum logic [BITS_DIR-1:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } dir_e;

    // Router port indices.
    localparam logic [SEL_W-1:0] PORT_N = 3'd0;
    localparam logic [SEL_W-1:0] PORT_E = 3'd1;
    localparam logic [SEL_W-1:0] PORT_S = 3'd2;
    localparam logic [SEL_W-1:0] PORT_W = 3'd3;
    localparam logic [SEL_W-1:0] PORT_L = 3'd4;

    typedef enum logic {
        OUT_IDLE,
        OUT_LOCKED
    } out_state_e;

    function automatic logic [SEL_W-1:0] dir_to_port(input logic [BITS_DIR-1:0] dir);
        case (dir)
            DIR_NORTH: return PORT_N;
            DIR_EAST:  return PORT_E;
            DIR_SOUTH: return PORT_S;
            DIR_WEST:  return PORT_W;
            default:   return PORT_L;
        endcase
    endfunction

    // Round-robin pointer advance: one past the winner, wrapping at NPORTS.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(NPORTS - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/switch_allocator_routing_table.sv
// XY dimension-ordered routing for the 3x3 mesh. Node address = y*3 + x,
// y grows southward, x grows eastward. X is resolved before Y.
module routing_table
    import switch_allocator_pkg::*;
(
    input  logic [ADDR_SZ-1:0]  id,
    input  logic [ADDR_SZ-1:0]  dest,
    output logic [BITS_DIR-1:0] dir
);

    logic [ADDR_SZ-1:0] cur_x;
    logic [ADDR_SZ-1:0] cur_y;
    logic [ADDR_SZ-1:0] dst_x;
    logic [ADDR_SZ-1:0] dst_y;

    // Split addresses into mesh coordinates and pick the XY direction.
    always_comb begin
        cur_x = id   % ADDR_SZ'(MESH_DIM);
        cur_y = id   / ADDR_SZ'(MESH_DIM);
        dst_x = dest % ADDR_SZ'(MESH_DIM);
        dst_y = dest / ADDR_SZ'(MESH_DIM);
        if (dst_x > cur_x) begin
            dir = DIR_EAST;
        end else if (dst_x < cur_x) begin
            dir = DIR_WEST;
        end else if (dst_y > cur_y) begin
            dir = DIR_SOUTH;
        end else if (dst_y < cur_y) begin
            dir = DIR_NORTH;
        end else begin
            dir = DIR_LOCAL;
        end
    end

endmodule

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first request found searching upward
// from ptr, wrapping past the last port back to port 0.
module rr_arbiter
    import switch_allocator_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NPORTS-1:0] gnt,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] cand;

    // Rotating priority search starting at ptr.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int unsigned step = 0; step < NPORTS; step++) begin
            sum = {1'b0, ptr} + (SEL_W + 1)'(step);
            if (sum >= (SEL_W + 1)'(NPORTS)) begin
                sum = sum - (SEL_W + 1)'(NPORTS);
            end
            cand = sum[SEL_W-1:0];
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator for one mesh router: routes head flits, arbitrates
// each output round-robin, and holds an output locked to its winning input
// until that packet's tail flit has been granted.
module switch_allocator
    import switch_allocator_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_SZ-1:0]        id,
    input  logic [NPORTS-1:0]         in_valid,
    input  logic [NPORTS-1:0]         in_head,
    input  logic [NPORTS-1:0]         in_tail,
    input  logic [NPORTS*ADDR_SZ-1:0] in_dest,
    input  logic [NPORTS-1:0]         out_ready,
    output logic [NPORTS-1:0]         grant,
    output logic [NPORTS*SEL_W-1:0]   xbar_sel,
    output logic [NPORTS-1:0]         xbar_valid,
    output logic                      proto_err
);

    out_state_e       state    [NPORTS];
    out_state_e       state_n  [NPORTS];
    logic [SEL_W-1:0] owner    [NPORTS];
    logic [SEL_W-1:0] owner_n  [NPORTS];
    logic [SEL_W-1:0] rr_ptr   [NPORTS];
    logic [SEL_W-1:0] rr_ptr_n [NPORTS];
    logic             proto_err_n;

    logic [BITS_DIR-1:0] dir      [NPORTS];
    logic [SEL_W-1:0]    route    [NPORTS];
    logic [NPORTS-1:0]   owner_oh [NPORTS];
    logic [NPORTS-1:0]   locked_in;
    logic [NPORTS-1:0]   req      [NPORTS];
    logic [NPORTS-1:0]   arb_gnt  [NPORTS];
    logic [SEL_W-1:0]    arb_idx  [NPORTS];
    logic                arb_any  [NPORTS];

    logic [NPORTS-1:0]       grant_c;
    logic [NPORTS-1:0]       xv_c;
    logic [NPORTS*SEL_W-1:0] sel_c;
    logic [NPORTS-1:0]       fire;

    // Per-port routing lookup and per-output arbiter.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        routing_table u_rt (
            .id   (id),
            .dest (in_dest[p*ADDR_SZ +: ADDR_SZ]),
            .dir  (dir[p])
        );

        assign route[p] = dir_to_port(dir[p]);

        rr_arbiter u_arb (
            .req (req[p]),
            .ptr (rr_ptr[p]),
            .gnt (arb_gnt[p]),
            .idx (arb_idx[p]),
            .any (arb_any[p])
        );
    end

    // Decode owners and flag inputs currently holding a locked output.
    always_comb begin
        locked_in = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            owner_oh[o] = '0;
            for (int unsigned k = 0; k < NPORTS; k++) begin
                if (owner[o] == SEL_W'(k)) begin
                    owner_oh[o][k] = 1'b1;
                end
            end
            if (state[o] == OUT_LOCKED) begin
                locked_in = locked_in | owner_oh[o];
            end
        end
    end

    // Head flits request the output they route to, unless already owning a lock.
    always_comb begin
        for (int unsigned o = 0; o < NPORTS; o++) begin
            req[o] = '0;
            for (int unsigned i = 0; i < NPORTS; i++) begin
                req[o][i] = in_valid[i] & in_head[i] & ~locked_in[i] &
                            (route[i] == SEL_W'(o));
            end
        end
    end

    // Per-output next state, grants and crossbar controls.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        proto_err_n = proto_err;
        grant_c     = '0;
        xv_c        = '0;
        sel_c       = '0;
        fire        = '0;
        for (int unsigned o = 0; o < NPORTS; o++) begin
            case (state[o])
                OUT_LOCKED: begin
                    sel_c[o*SEL_W +: SEL_W] = owner[o];
                    fire[o] = (|(owner_oh[o] & in_valid)) & out_ready[o];
                    if (fire[o]) begin
                        xv_c[o] = 1'b1;
                        grant_c = grant_c | owner_oh[o];
                        if (|(owner_oh[o] & in_tail)) begin
                            state_n[o] = OUT_IDLE;
                        end
                        if (|(owner_oh[o] & in_head)) begin
                            proto_err_n = 1'b1;
                        end
                    end
                end
                default: begin
                    if (out_ready[o] && arb_any[o]) begin
                        xv_c[o] = 1'b1;
                        sel_c[o*SEL_W +: SEL_W] = arb_idx[o];
                        grant_c = grant_c | arb_gnt[o];
                        rr_ptr_n[o] = next_ptr(arb_idx[o]);
                        // single-flit packets leave the output free
                        if ((arb_gnt[o] & in_tail) == '0) begin
                            state_n[o] = OUT_LOCKED;
                            owner_n[o] = arb_idx[o];
                        end
                    end
                end
            endcase
        end
    end

    // Hold all datapath controls quiet while reset is asserted.
    always_comb begin
        grant      = rst_n ? grant_c : '0;
        xbar_valid = rst_n ? xv_c    : '0;
        xbar_sel   = rst_n ? sel_c   : '0;
    end

    // State, owner, pointer and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < NPORTS; o++) begin
                state[o]  <= OUT_IDLE;
                owner[o]  <= '0;
                rr_ptr[o] <= '0;
            end
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            proto_err <= proto_err_n;
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: a sequential vector table plus a
// hand-written locked-packet sequence, checked through an expectation queue.
module tb_switch_allocator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id;
    logic [4:0]  in_valid;
    logic [4:0]  in_head;
    logic [4:0]  in_tail;
    logic [19:0] in_dest;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [14:0] xbar_sel;
    logic [4:0]  xbar_valid;
    logic        proto_err;

    always #5 clk = ~clk;

    switch_allocator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id         (id),
        .in_valid   (in_valid),
        .in_head    (in_head),
        .in_tail    (in_tail),
        .in_dest    (in_dest),
        .out_ready  (out_ready),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .xbar_valid (xbar_valid),
        .proto_err  (proto_err)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  id;
        logic [4:0]  valid;
        logic [4:0]  head;
        logic [4:0]  tail;
        logic [19:0] dest;
        logic [4:0]  ready;
        logic [4:0]  exp_grant;
        logic [4:0]  exp_xv;
        logic [14:0] exp_sel;
        logic        exp_err;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  grant;
        logic [4:0]  xv;
        logic [14:0] sel;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Destination fields, index 0 (N) first.
    function automatic logic [19:0] d5(input int a0, input int a1, input int a2,
                                       input int a3, input int a4);
        return {4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    // Crossbar selects, output 0 (N) first.
    function automatic logic [14:0] s5(input int s0, input int s1, input int s2,
                                       input int s3, input int s4);
        return {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    function automatic vec_t mk(input string name, input logic rst, input int vid,
                                input logic [4:0] valid, input logic [4:0] head,
                                input logic [4:0] tail, input logic [19:0] dest,
                                input logic [4:0] ready, input logic [4:0] eg,
                                input logic [4:0] exv, input logic [14:0] esel,
                                input logic eerr);
        vec_t v;
        v.name = name; v.rst = rst; v.id = 4'(vid);
        v.valid = valid; v.head = head; v.tail = tail; v.dest = dest; v.ready = ready;
        v.exp_grant = eg; v.exp_xv = exv; v.exp_sel = esel; v.exp_err = eerr;
        return v;
    endfunction

    task automatic check_next();
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty: got no expectation, required one queued");
            return;
        end
        e = sb.pop_front();
        if (grant !== e.grant || xbar_valid !== e.xv || xbar_sel !== e.sel ||
            proto_err !== e.err) begin
            n_miss++;
            $display("FAIL %s: got grant=%b xv=%b sel=%h err=%b, required grant=%b xv=%b sel=%h err=%b",
                     e.name, grant, xbar_valid, xbar_sel, proto_err,
                     e.grant, e.xv, e.sel, e.err);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n     = v.rst;
        id        = v.id;
        in_valid  = v.valid;
        in_head   = v.head;
        in_tail   = v.tail;
        in_dest   = v.dest;
        out_ready = v.ready;
        e.name = v.name; e.grant = v.exp_grant; e.xv = v.exp_xv;
        e.sel  = v.exp_sel; e.err = v.exp_err;
        sb.push_back(e);
        #2;
        check_next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish within time limit, required finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] rdy;
        rst_n = 1'b0; id = 4'd4; in_valid = '0; in_head = '0; in_tail = '0;
        in_dest = '0; out_ready = '0;

        vecs.push_back(mk("reset_hold",     0, 4, 5'b11111, 5'b11111, 5'b00000, d5(5,5,5,5,5), 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("idle_empty",     1, 4, 5'b00000, 5'b00000, 5'b00000, d5(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("single_flit",    1, 4, 5'b10000, 5'b10000, 5'b10000, d5(0,0,0,0,5), 5'b11111, 5'b10000, 5'b00010, s5(0,4,0,0,0), 0));
        vecs.push_back(mk("contend_head",   1, 4, 5'b01001, 5'b01001, 5'b00000, d5(5,0,0,5,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("body_w_waits",   1, 4, 5'b01001, 5'b01000, 5'b00000, d5(5,0,0,5,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("locked_not_rdy", 1, 4, 5'b01001, 5'b01000, 5'b00000, d5(5,0,0,5,0), 5'b11101, 5'b00000, 5'b00000, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("tail_n",         1, 4, 5'b01001, 5'b01000, 5'b00001, d5(5,0,0,5,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("w_no_bubble",    1, 4, 5'b01000, 5'b01000, 5'b00000, d5(0,0,0,5,0), 5'b11111, 5'b01000, 5'b00010, s5(0,3,0,0,0), 0));
        vecs.push_back(mk("w_tail",         1, 4, 5'b01000, 5'b00000, 5'b01000, d5(0,0,0,5,0), 5'b11111, 5'b01000, 5'b00010, s5(0,3,0,0,0), 0));
        vecs.push_back(mk("rr_from4",       1, 4, 5'b10101, 5'b10101, 5'b10101, d5(5,0,5,0,5), 5'b11111, 5'b10000, 5'b00010, s5(0,4,0,0,0), 0));
        vecs.push_back(mk("rr_from0",       1, 4, 5'b00101, 5'b00101, 5'b00101, d5(5,0,5,0,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("rr_from1",       1, 4, 5'b00101, 5'b00101, 5'b00101, d5(5,0,5,0,0), 5'b11111, 5'b00100, 5'b00010, s5(0,2,0,0,0), 0));
        vecs.push_back(mk("parallel",       1, 4, 5'b01111, 5'b01111, 5'b01111, d5(3,1,4,7,0), 5'b11111, 5'b01111, 5'b11101, s5(1,0,3,0,2), 0));
        vecs.push_back(mk("err_lock",       1, 4, 5'b00001, 5'b00001, 5'b00000, d5(5,0,0,0,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("second_head",    1, 4, 5'b00001, 5'b00001, 5'b00000, d5(5,0,0,0,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("err_seen",       1, 4, 5'b00000, 5'b00000, 5'b00000, d5(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 1));
        vecs.push_back(mk("err_tail",       1, 4, 5'b00001, 5'b00000, 5'b00001, d5(0,0,0,0,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 1));
        vecs.push_back(mk("err_sticky",     1, 4, 5'b00000, 5'b00000, 5'b00000, d5(0,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 1));
        vecs.push_back(mk("relock_n",       1, 4, 5'b00001, 5'b00001, 5'b00000, d5(5,0,0,0,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 1));
        vecs.push_back(mk("relock_body",    1, 4, 5'b00001, 5'b00000, 5'b00000, d5(5,0,0,0,0), 5'b11111, 5'b00001, 5'b00010, s5(0,0,0,0,0), 1));
        vecs.push_back(mk("reset_mid",      0, 4, 5'b00001, 5'b00000, 5'b00000, d5(5,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("orphan_body",    1, 4, 5'b00001, 5'b00000, 5'b00000, d5(5,0,0,0,0), 5'b11111, 5'b00000, 5'b00000, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("fresh_s_head",   1, 4, 5'b00101, 5'b00100, 5'b00000, d5(5,0,5,0,0), 5'b11111, 5'b00100, 5'b00010, s5(0,2,0,0,0), 0));
        vecs.push_back(mk("s_tail",         1, 4, 5'b00100, 5'b00000, 5'b00100, d5(0,0,5,0,0), 5'b11111, 5'b00100, 5'b00010, s5(0,2,0,0,0), 0));
        vecs.push_back(mk("idle_not_rdy",   1, 4, 5'b00001, 5'b00001, 5'b00001, d5(5,0,0,0,0), 5'b11101, 5'b00000, 5'b00000, s5(0,0,0,0,0), 0));
        vecs.push_back(mk("ready_back",     1, 4, 5'b01001, 5'b01001, 5'b01001, d5(5,0,0,5,0), 5'b11111, 5'b01000, 5'b00010, s5(0,3,0,0,0), 0));
        vecs.push_back(mk("corner_id0",     1, 0, 5'b10010, 5'b10010, 5'b10010, d5(0,0,0,0,8), 5'b11111, 5'b10010, 5'b10010, s5(0,4,0,0,1), 0));
        vecs.push_back(mk("corner_id8",     1, 8, 5'b00101, 5'b00101, 5'b00101, d5(6,0,2,0,0), 5'b11111, 5'b00101, 5'b01001, s5(2,0,0,0,0), 0));

        foreach (vecs[n]) apply(vecs[n]);

        // LOCAL holds E through a multi-flit packet under random backpressure
        // while W keeps a head waiting for the same output.
        apply(mk("seq_lock_local", 1, 4, 5'b10000, 5'b10000, 5'b00000, d5(0,0,0,0,5), 5'b11111,
                 5'b10000, 5'b00010, s5(0,4,0,0,0), 0));
        for (int c = 0; c < 8; c++) begin
            rdy    = 5'($urandom_range(0, 31));
            rdy[1] = (c % 3 != 1);
            apply(mk($sformatf("seq_body_%0d", c), 1, 4, 5'b11000, 5'b01000, 5'b00000,
                     d5(0,0,0,5,5), rdy, {rdy[1], 4'b0000}, {3'b000, rdy[1], 1'b0},
                     s5(0,4,0,0,0), 0));
        end
        apply(mk("seq_tail_local", 1, 4, 5'b11000, 5'b01000, 5'b10000, d5(0,0,0,5,5), 5'b11111,
                 5'b10000, 5'b00010, s5(0,4,0,0,0), 0));
        apply(mk("seq_w_next", 1, 4, 5'b01000, 5'b01000, 5'b01000, d5(0,0,0,5,0), 5'b11111,
                 5'b01000, 5'b00010, s5(0,3,0,0,0), 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-router wormhole switch allocator for the 3x3 mesh NoC.
- Takes the head/body/tail flit status of the five router input ports (N, E, S, W, LOCAL). Routes each head flit through one XY routing_table instance per input, then arbitrates each output port round-robin among competing heads.
- Holds each output locked to its winning input until that packet's tail flit has passed.
- Drives the crossbar select lines and per-input dequeue grants. It sits between the input FIFOs and the crossbar.

Parameters:
- NPORTS, 5, number of router ports. Fixed at 5; index 0=N, 1=E, 2=S, 3=W, 4=LOCAL.
- SEL_W, 3, width of one crossbar select field (ceil log2 NPORTS).
- ADDR_SZ and BITS_DIR come from the global defines, not from parameters.

Ports:
- clk  in  1  router clock.
- rst_n  in  1  asynchronous, active-low reset.
- id  in  ADDR_SZ  this router's node address (0..8).
- in_valid  in  NPORTS  input FIFO i holds a flit.
- in_head  in  NPORTS  flit at FIFO i head is a head flit.
- in_tail  in  NPORTS  flit at FIFO i head is a tail flit. Head and tail both set means a single-flit packet.
- in_dest  in  NPORTS*ADDR_SZ  destination field of the flit at FIFO i. Only meaningful when in_head is set. Slice i occupies bits [i*ADDR_SZ +: ADDR_SZ].
- out_ready  in  NPORTS  downstream of output o can accept a flit this cycle.
- grant  out  NPORTS  dequeue flit from input i this cycle. Combinational from current state and inputs.
- xbar_sel  out  NPORTS*SEL_W  input index driving output o. Slice o occupies bits [o*SEL_W +: SEL_W].
- xbar_valid  out  NPORTS  output o carries a valid flit this cycle.
- proto_err  out  1  sticky flag: a protocol violation was detected.

Behaviour:
- Reset (rst_n low, asynchronous) puts every output in IDLE, sets owner=0 and rr_ptr=0, and clears proto_err.
- While in reset, grant=0, xbar_valid=0 and xbar_sel=0.
- Routing: route[i] = routing_table(id, in_dest[i]) converted to a port index using the direction-to-index map in the shared constants.
- Per-output state is IDLE or LOCKED(owner). Each output also keeps an rr_ptr register (SEL_W bits).
- IDLE, candidate set: input i is a candidate for output o when in_valid[i] & in_head[i] & route[i]==o, and input i is not the owner of any LOCKED output.
- IDLE, arbitration: done only when out_ready[o]=1. The winner is the first candidate found searching from rr_ptr upward, wrapping 4->0.
- IDLE, winner handling:
  - grant[winner]=1, xbar_valid[o]=1, xbar_sel[o]=winner, all in the same cycle (zero added latency).
  - At the clock edge, rr_ptr <= (winner+1) mod 5.
  - If the winning flit is not also a tail, the output goes to LOCKED(winner). If it is a tail (single-flit packet), the output stays IDLE.
- IDLE with out_ready=0 or no candidates: no grant, rr_ptr unchanged, state unchanged.
- LOCKED(k):
  - xbar_sel[o]=k at all times.
  - grant[k] = xbar_valid[o] = in_valid[k] & out_ready[o].
  - A granted flit with in_tail[k] set returns the output to IDLE at the next edge.
  - Arbitration for this output is suspended while LOCKED.
- A granted head flit on a LOCKED owner sets proto_err and is forwarded as a body flit. proto_err clears only on reset.
- Each input is granted by at most one output per cycle; the route is unique per head flit.
- Two heads contending for the same output: exactly one wins per cycle. The loser is held in its FIFO (no grant) and retries on later cycles.
- An output going IDLE at edge t can arbitrate a new head in cycle t+1. There is no bubble beyond that one edge.
- A body flit on an input with no LOCKED output is never granted.
- Reset mid-packet: all locks drop immediately, and the remainder of the packet follows the body-flit-without-lock rule above. Flushing those flits is the responsibility of the input FIFO reset.

Decomposition:
- Shared constants/package:
  - direction encodings (NORTH/EAST/SOUTH/WEST/LOCAL) and the direction-to-port-index map;
  - NPORTS, SEL_W;
  - ADDR_SZ and BITS_DIR, already global defines.
- Sub-module rr_arbiter: 5-bit request vector plus pointer in, one-hot grant plus encoded index out. It is purely combinational.
- switch_allocator instantiates 5 routing_table and 5 rr_arbiter instances, and holds the state, owner and rr_ptr registers.

Test Plan:
- id=4, input LOCAL single-flit packet (head=tail=1) to dest=5, out_ready=all 1 -> same cycle grant[4]=1, xbar_valid[1]=1, xbar_sel[1]=4; next cycle output E is IDLE and rr_ptr[E]=0 (winner 4, wrapped).
- id=4, N and W both send a head to dest=5, rr_ptr[E]=0 -> N wins cycle 0 and E locks. W gets no grant until N's tail is granted; W's head is granted the cycle after that.
- Locked E owner N, 3-flit packet, out_ready[1] low in cycle 1 -> grant[0]=0 and xbar_valid[1]=0 in cycle 1; body resumes when ready returns; unlock after the tail.
- id=4, heads at dest=1, 7, 3, 4 on inputs E, W, N, S in the same cycle -> outputs N, S, W, LOCAL are granted in parallel: xbar_sel N=1, S=3, W=0, LOCAL=2.
- Second head flit arriving on the owner input while LOCKED -> proto_err rises one cycle later and stays high until rst_n.
- Assert rst_n low mid-packet (E locked to N) -> grant and xbar_valid go to 0 immediately. After release, N's remaining body flit gets no grant, and a fresh head from S to E is granted.
